activation_scheduler: RTL and testbench
=======================================

// Module: activation_scheduler
// PURPOSE
//  Round-robin arbiter and sequencer sharing one activation engine (relu-style unit:
//  enable in, done out) among NUM_REQ layer requesters. Grants one requester at a time,
//  drives the engine's source-mux select and function code, runs the enable/done
//  handshake, and returns a completion (ack) or timeout (err) pulse to the winner.
//  Vector data is muxed outside this block by act_src_sel.
// PARAMETERS
//  NUM_REQ  4    number of requesters (>=2)
//  FUNC_W   2    function-code width (0 ReLU, 1 sigmoid, 2 tanh, 3 bypass)
//  TIMEOUT  255  max RUN cycles waiting for act_done before err (>=2)
//  CNT_W    8    run-counter width; must hold TIMEOUT
// PORTS
//  clk          in   1                  system clock, rising edge
//  reset        in   1                  asynchronous, active-high reset
//  req          in   NUM_REQ            level request per requester
//  req_func     in   NUM_REQ*FUNC_W     function code per requester, slice i = [i*FUNC_W +: FUNC_W]
//  gnt          out  NUM_REQ            one-hot grant, held GRANT..DRAIN
//  ack          out  NUM_REQ            1-cycle completion pulse to granted requester
//  err          out  NUM_REQ            1-cycle timeout pulse to granted requester
//  act_enable   out  1                  engine enable
//  act_func     out  FUNC_W             engine function code, latched at grant
//  act_src_sel  out  $clog2(NUM_REQ)    engine input/output mux select
//  act_done     in   1                  engine completion, level
//  busy         out  1                  high whenever state != IDLE
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, cnt 0, last_winner = NUM_REQ-1 (req[0] highest priority).
//  All outputs registered. FSM states: IDLE, GRANT, RUN, DRAIN.
//  IDLE: if |req, winner = first set bit searching last_winner+1 upward with wrap;
//   gnt <= onehot(winner), act_src_sel <= winner, act_func <= req_func slice -> GRANT.
//  GRANT (1 cycle, mux settle): act_enable <= 1, cnt <= 0 -> RUN.
//  RUN: act_done=1 -> act_enable <= 0, ack[winner] <= 1 -> DRAIN;
//   else cnt==TIMEOUT-1 -> act_enable <= 0, err[winner] <= 1 -> DRAIN; else cnt++.
//   act_done and timeout in same cycle: ack wins, no err.
//  DRAIN: ack/err <= 0; if act_done=0: gnt <= 0, last_winner <= winner -> IDLE;
//   else remain in DRAIN (gnt held) until engine drops done.
//  Latency: req sampled at edge k -> gnt at k, act_enable at k+1; act_done sampled at
//   edge d -> ack pulse for cycle d..d+1, gnt low one edge later (if done low).
//  Minimum gap between grants: one IDLE cycle.
//  req deassertion after grant is ignored; transaction runs to ack/err (no abort).
//  req_func changes after grant do not affect act_func.
//  act_done outside RUN/DRAIN is ignored.
//  Reset asserted mid-transaction: immediate return to reset values; no ack/err emitted.
//  ack and err never both set; at most one bit of gnt/ack/err set at any time.
// TESTING
//  req=0001, func0=0, done 10 cycles after enable -> gnt=0001, act_func=0, ack[0] 1 cycle, busy low after DRAIN.
//  req=1111 held, done after 3 cycles each -> grant order 0,1,2,3,0; act_src_sel tracks; no starvation.
//  req=0100, act_done never -> err[2] after exactly TIMEOUT RUN cycles, act_enable low, no ack.
//  act_done rises on cycle TIMEOUT-1 of RUN -> ack only, err stays 0.
//  done held high 5 cycles past ack -> state stays DRAIN, gnt held, then IDLE when done falls.
//  reset pulse during RUN with req=0010 -> all outputs 0 asynchronously; next grant goes to req[0] if set.

Source files
------------

// File: rtl/activation_scheduler.sv
// Round-robin arbiter/sequencer sharing one activation engine among NUM_REQ requesters.
// Runs the enable/done handshake and returns a one-cycle ack or timeout err to the winner.
`timescale 1ns/1ps
module activation_scheduler #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned FUNC_W  = 2,
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*FUNC_W-1:0]  req_func,
  output logic [NUM_REQ-1:0]         gnt,
  output logic [NUM_REQ-1:0]         ack,
  output logic [NUM_REQ-1:0]         err,
  output logic                       act_enable,
  output logic [FUNC_W-1:0]          act_func,
  output logic [$clog2(NUM_REQ)-1:0] act_src_sel,
  input  logic                       act_done,
  output logic                       busy
);

  localparam int unsigned SEL_W = $clog2(NUM_REQ);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_RUN   = 2'd2,
    S_DRAIN = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [NUM_REQ-1:0] ack_q, ack_d;
  logic [NUM_REQ-1:0] err_q, err_d;
  logic               enable_q, enable_d;
  logic [FUNC_W-1:0]  func_q, func_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [SEL_W-1:0]   last_q, last_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               busy_q, busy_d;

  logic [SEL_W-1:0]   win_c;
  int unsigned        win_idx;
  logic [FUNC_W-1:0]  func_arr [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_func
    assign func_arr[g] = req_func[g*FUNC_W +: FUNC_W];
  end

  // Descending scan so the requester closest after last_q is the final assignment.
  always_comb begin
    win_c   = last_q;
    win_idx = 0;
    for (int unsigned i = NUM_REQ; i >= 1; i--) begin
      win_idx = (32'(last_q) + i) % NUM_REQ;
      if (req[SEL_W'(win_idx)]) win_c = SEL_W'(win_idx);
    end
  end

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    ack_d    = '0;
    err_d    = '0;
    enable_d = enable_q;
    func_d   = func_q;
    sel_d    = sel_q;
    last_d   = last_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (|req) begin
          gnt_d   = NUM_REQ'(1) << win_c;
          sel_d   = win_c;
          func_d  = func_arr[win_c];
          state_d = S_GRANT;
        end
      end
      S_GRANT: begin
        enable_d = 1'b1;
        cnt_d    = '0;
        state_d  = S_RUN;
      end
      S_RUN: begin
        // Completion takes priority over a coincident timeout.
        if (act_done) begin
          enable_d = 1'b0;
          ack_d    = NUM_REQ'(1) << sel_q;
          state_d  = S_DRAIN;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          enable_d = 1'b0;
          err_d    = NUM_REQ'(1) << sel_q;
          state_d  = S_DRAIN;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DRAIN: begin
        if (!act_done) begin
          gnt_d   = '0;
          last_d  = sel_q;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      gnt_q    <= '0;
      ack_q    <= '0;
      err_q    <= '0;
      enable_q <= 1'b0;
      func_q   <= '0;
      sel_q    <= '0;
      last_q   <= SEL_W'(NUM_REQ - 1);
      cnt_q    <= '0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      ack_q    <= ack_d;
      err_q    <= err_d;
      enable_q <= enable_d;
      func_q   <= func_d;
      sel_q    <= sel_d;
      last_q   <= last_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
    end
  end

  assign gnt         = gnt_q;
  assign ack         = ack_q;
  assign err         = err_q;
  assign act_enable  = enable_q;
  assign act_func    = func_q;
  assign act_src_sel = sel_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_activation_scheduler.sv
// Directed bench for activation_scheduler: scoreboard of expected grants/completions
// checked with immediate assertions.
`timescale 1ns/1ps
module tb_activation_scheduler;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned FUNC_W  = 2;
  localparam int unsigned TIMEOUT = 255;
  localparam int unsigned CNT_W   = 8;
  localparam int unsigned SEL_W   = 2;

  logic                      clk = 1'b0;
  logic                      reset;
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*FUNC_W-1:0] req_func;
  logic [NUM_REQ-1:0]        gnt, ack, err;
  logic                      act_enable;
  logic [FUNC_W-1:0]         act_func;
  logic [SEL_W-1:0]          act_src_sel;
  logic                      act_done;
  logic                      busy;

  typedef struct {
    int unsigned       id;
    logic [FUNC_W-1:0] func;
    bit                is_err;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  activation_scheduler #(
    .NUM_REQ(NUM_REQ), .FUNC_W(FUNC_W), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset), .req(req), .req_func(req_func),
    .gnt(gnt), .ack(ack), .err(err), .act_enable(act_enable),
    .act_func(act_func), .act_src_sel(act_src_sel), .act_done(act_done),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
  endtask

  task automatic push_exp(input int unsigned id, input bit is_err);
    exp_t e;
    e.id     = id;
    e.func   = req_func[id*FUNC_W +: FUNC_W];
    e.is_err = is_err;
    sb.push_back(e);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_gnt"},  32'(gnt), 32'd0);
    check({tag, "_ack"},  32'(ack), 32'd0);
    check({tag, "_err"},  32'(err), 32'd0);
    check({tag, "_en"},   32'(act_enable), 32'd0);
    check({tag, "_func"}, 32'(act_func), 32'd0);
    check({tag, "_sel"},  32'(act_src_sel), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  // Waits for a grant and compares it with the oldest pending expectation.
  task automatic wait_grant();
    int   lat;
    exp_t e;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (gnt == '0 && lat < 20);
    check("grant_latency", 32'(lat), 32'd1);
    check("sb_has_grant", 32'(sb.size() != 0), 32'd1);
    if (sb.size() != 0) begin
      e = sb[0];
      check("gnt_onehot", 32'(gnt), 32'(1) << e.id);
      check("grant_sel", 32'(act_src_sel), e.id);
      check("grant_func", 32'(act_func), 32'(e.func));
      check("grant_en_low", 32'(act_enable), 32'd0);
      check("grant_busy", 32'(busy), 32'd1);
    end
  endtask

  // Engine model: raise done 'delay' cycles after enable (never if negative),
  // hold it 'hold' cycles past the completion pulse, then release.
  task automatic engine(input int delay, input int hold, input int exp_lat);
    int          n;
    exp_t        e;
    logic [31:0] oh;
    n = 0;
    while (!act_enable && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("enable_rise", 32'(act_enable), 32'd1);
    n = 0;
    do begin
      if (delay >= 0 && n == delay) act_done = 1'b1;
      @(negedge clk);
      n++;
    end while (ack == '0 && err == '0 && n < int'(TIMEOUT) + 20);
    check("done_latency", 32'(n), 32'(exp_lat));
    check("sb_has_done", 32'(sb.size() != 0), 32'd1);
    if (sb.size() != 0) begin
      e  = sb.pop_front();
      oh = 32'(1) << e.id;
      check("ack", 32'(ack), e.is_err ? 32'd0 : oh);
      check("err", 32'(err), e.is_err ? oh : 32'd0);
      check("done_en_low", 32'(act_enable), 32'd0);
      check("done_gnt", 32'(gnt), oh);
      check("done_func", 32'(act_func), 32'(e.func));
      for (int h = 0; h < hold; h++) begin
        @(negedge clk);
        check("drain_gnt", 32'(gnt), oh);
        check("drain_pulse", 32'(ack | err), 32'd0);
        check("drain_busy", 32'(busy), 32'd1);
      end
    end
    act_done = 1'b0;
    @(negedge clk);
    check("release_gnt", 32'(gnt), 32'd0);
    check("release_pulse", 32'(ack | err), 32'd0);
    check("release_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    int unsigned order [5] = '{0, 1, 2, 3, 0};
    reset    = 1'b1;
    req      = '0;
    act_done = 1'b0;
    req_func = {2'd3, 2'd2, 2'd1, 2'd0};
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    reset = 1'b0;

    // All requesters held: fair rotation starting at requester 0.
    req = 4'b1111;
    for (int k = 0; k < 5; k++) push_exp(order[k], 1'b0);
    for (int k = 0; k < 5; k++) begin
      wait_grant();
      if (k == 4) req = '0;
      engine(2, 0, 3);
    end

    // Single requester; req drop and req_func change after grant are ignored.
    req = 4'b0001;
    push_exp(0, 1'b0);
    wait_grant();
    req      = '0;
    req_func = '1;
    engine(10, 0, 11);
    req_func = {2'd3, 2'd2, 2'd1, 2'd0};

    // Engine never completes: err after exactly TIMEOUT RUN cycles.
    req = 4'b0100;
    push_exp(2, 1'b1);
    wait_grant();
    req = '0;
    engine(-1, 0, int'(TIMEOUT));

    // Done coincides with the final RUN cycle: ack wins.
    req = 4'b1000;
    push_exp(3, 1'b0);
    wait_grant();
    req = '0;
    engine(int'(TIMEOUT) - 1, 0, int'(TIMEOUT));

    // Done held past ack keeps the grant in DRAIN.
    req = 4'b0001;
    push_exp(0, 1'b0);
    wait_grant();
    req = '0;
    engine(1, 5, 2);

    // Asynchronous reset mid-RUN, then priority restarts at requester 0.
    req = 4'b0010;
    push_exp(1, 1'b0);
    wait_grant();
    repeat (3) @(negedge clk);
    check("pre_reset_en", 32'(act_enable), 32'd1);
    #2 reset = 1'b1;
    #1 check_all_zero("async_reset");
    void'(sb.pop_front());
    req = 4'b0011;
    push_exp(0, 1'b0);
    @(negedge clk);
    check("reset_no_pulse", 32'(ack | err), 32'd0);
    reset = 1'b0;
    wait_grant();
    req = '0;
    engine(0, 0, 1);

    repeat (3) @(negedge clk);
    check("final_idle", 32'(busy), 32'd0);
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
